xor_cipher_ctrl: RTL and testbench
==================================

// Module: xor_cipher_ctrl
// PURPOSE
//  Sequencer for the 32-bit Galois LFSR keystream generator in the XOR cipher datapath.
//  Loads seed/taps into the LFSR and accepts plaintext/ciphertext bytes over valid/ready.
//  Steps the LFSR DATA_W times per byte to gather keystream bit k, LSB first, then returns data^keystream.
//  Sits between the chip I/O wrapper and the galois_lfsr instance; the LFSR's own rst is tied inactive.
// PARAMETERS
//  DATA_W      8             data word width = LFSR steps per word (1..32)
//  LFSR_W      32            LFSR state/taps width
//  RESET_TAPS  32'h80200003  taps value held in taps register after reset
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  seed_i     in   LFSR_W  seed value, sampled when seed_ld=1
//  taps_i     in   LFSR_W  feedback taps, sampled when seed_ld=1
//  seed_ld    in   1       single-cycle request: latch seed_i/taps_i and (re)load LFSR
//  in_valid   in   1       input word valid
//  in_ready   out  1       controller can accept a word
//  in_data    in   DATA_W  input word
//  out_valid  out  1       result word valid
//  out_ready  in   1       sink accepts result
//  out_data   out  DATA_W  in_data ^ keystream word
//  busy       out  1       state != IDLE or seed load pending
//  lfsr_ld    out  1       to LFSR ld
//  lfsr_en    out  1       to LFSR en
//  lfsr_seed  out  LFSR_W  to LFSR lfsr_i (registered seed)
//  lfsr_taps  out  LFSR_W  to LFSR taps (registered taps)
//  lfsr_k     in   1       from LFSR k (= state bit 0)
// BEHAVIOUR
//  - Reset: state=IDLE, seeded=0, pend=0, seed reg=0, taps reg=RESET_TAPS, out_data=0.
//    All outputs 0 except lfsr_taps. Reset mid-word discards the word.
//  - FSM IDLE -> LOAD -> IDLE; IDLE -> GEN -> OUT -> IDLE.
//  - seed_ld in any state: seed/taps regs capture seed_i/taps_i that cycle; pend<=1.
//    A second seed_ld before service overwrites the regs; only one load is performed.
//  - IDLE with pend=1: go to LOAD (priority over input).
//  - LOAD (1 cycle): lfsr_ld=1; LFSR holds seed from the next edge. pend<=0, seeded<=1.
//  - seed_ld during GEN/OUT does not disturb the current word; the load runs on return to IDLE.
//  - in_ready = (state==IDLE) & seeded & ~pend & ~seed_ld (combinational).
//    Handshake in cycle T: latch in_data, cnt<=0, go to GEN.
//  - GEN (DATA_W cycles): lfsr_en=1; ks[cnt]<=lfsr_k; cnt++; leave after cnt==DATA_W-1.
//  - OUT: out_valid=1 from T+DATA_W+1; out_data stable until out_ready=1, then go to IDLE.
//    Earliest next accept is the cycle after the OUT handshake (3-state loop, no overlap).
//  - lfsr_en=0 outside GEN; lfsr_ld=0 outside LOAD. The keystream continues across words until the next seed load.
//  - cnt width = $clog2(DATA_W)+1; no wrap within a word.
// CONFIGURATION
//  XORC_BYTE_CNT_EN defined: adds output port byte_cnt [31:0].
//    Counts OUT handshakes, wraps 32'hFFFFFFFF->0, and clears to 0 in the LOAD cycle and on reset.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset mid-GEN (rst_n low 1 cycle) -> state IDLE, out_valid=0, in_ready=0 until next seed_ld+LOAD.
//  2. seed_ld(seed=32'h1, taps=32'h80200003), word 8'h00 -> out_data=8'hDB; out_valid 9 cycles after accept.
//  3. Same seed, words 8'hFF then 8'h00 -> 8'h24, then the next 8 keystream bits (no reload between words).
//  4. Reload seed 32'h1, input 8'hDB -> 8'h00 (decrypt round trip).
//  5. out_ready=0 for 5 cycles -> out_valid and out_data held, in_ready=0.
//     seed_ld during that hold -> word unchanged, LOAD follows OUT.
//  6. seed_ld and in_valid in the same IDLE cycle -> in_ready=0, LOAD first, word accepted after.
//     With XORC_BYTE_CNT_EN, byte_cnt is 0 after LOAD and increments to 1 after the word.

Source files
------------

// File: rtl/xor_cipher_ctrl.sv
// Sequencer for a Galois LFSR keystream generator: loads seed/taps, gathers DATA_W keystream bits per word and returns data ^ keystream.
// Optional: define XORC_BYTE_CNT_EN to add the byte_cnt output (count of delivered words).
module xor_cipher_ctrl #(
    parameter int unsigned          DATA_W     = 8,
    parameter int unsigned          LFSR_W     = 32,
    parameter logic [LFSR_W-1:0]    RESET_TAPS = LFSR_W'(32'h80200003)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic [LFSR_W-1:0] taps_i,
    input  logic              seed_ld,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              lfsr_ld,
    output logic              lfsr_en,
    output logic [LFSR_W-1:0] lfsr_seed,
    output logic [LFSR_W-1:0] lfsr_taps,
`ifdef XORC_BYTE_CNT_EN
    output logic [31:0]       byte_cnt,
`endif
    input  logic              lfsr_k
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GEN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_d;
    logic                pend;
    logic                pend_d;
    logic                seeded;
    logic [CNT_W-1:0]    cnt;
    logic                cnt_last;
    logic [DATA_W-1:0]   ks;
    logic [DATA_W-1:0]   ks_next;
    logic [DATA_W-1:0]   data_q;

    assign in_ready = (state == IDLE) & seeded & ~pend & ~seed_ld;
    assign cnt_last = (cnt == CNT_W'(DATA_W - 1));

    // Next-state: a pending seed load outranks a new word.
    always_comb begin
        state_d = state;
        pend_d  = seed_ld | (pend & (state != LOAD));
        case (state)
            IDLE: begin
                if (pend) begin
                    state_d = LOAD;
                end else if (in_valid && in_ready) begin
                    state_d = GEN;
                end
            end
            LOAD: state_d = IDLE;
            GEN: begin
                if (cnt_last) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Keystream word with the current LFSR bit merged in at position cnt.
    always_comb begin
        ks_next = ks;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (cnt == CNT_W'(i)) begin
                ks_next[i] = lfsr_k;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= 1'b0;
            seeded    <= 1'b0;
            cnt       <= '0;
            ks        <= '0;
            data_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            lfsr_ld   <= 1'b0;
            lfsr_en   <= 1'b0;
            lfsr_seed <= '0;
            lfsr_taps <= RESET_TAPS;
`ifdef XORC_BYTE_CNT_EN
            byte_cnt  <= '0;
`endif
        end else begin
            state     <= state_d;
            pend      <= pend_d;
            busy      <= (state_d != IDLE) | pend_d;
            out_valid <= (state_d == OUT);
            lfsr_en   <= (state_d == GEN);
            lfsr_ld   <= (state_d == LOAD);

            if (seed_ld) begin
                lfsr_seed <= seed_i;
                lfsr_taps <= taps_i;
            end

            case (state)
                IDLE: begin
                    if (!pend && in_valid && in_ready) begin
                        data_q <= in_data;
                        cnt    <= '0;
                    end
                end
                LOAD: seeded <= 1'b1;
                GEN: begin
                    ks  <= ks_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt_last) begin
                        out_data <= data_q ^ ks_next;
                    end
                end
                default: ;
            endcase

`ifdef XORC_BYTE_CNT_EN
            if (state == LOAD) begin
                byte_cnt <= '0;
            end else if (state == OUT && out_ready) begin
                byte_cnt <= byte_cnt + 32'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Self-checking bench for xor_cipher_ctrl with a behavioural right-shift Galois LFSR as the keystream source.
module tb_xor_cipher_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] seed_i;
    logic [31:0] taps_i;
    logic        seed_ld;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        lfsr_ld;
    logic        lfsr_en;
    logic [31:0] lfsr_seed;
    logic [31:0] lfsr_taps;
    logic        lfsr_k;
`ifdef XORC_BYTE_CNT_EN
    logic [31:0] byte_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] lfsr_st = 32'h0;

    always #5 clk = ~clk;

    xor_cipher_ctrl #(.DATA_W(8), .LFSR_W(32), .RESET_TAPS(32'h80200003)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_i    (seed_i),
        .taps_i    (taps_i),
        .seed_ld   (seed_ld),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .lfsr_ld   (lfsr_ld),
        .lfsr_en   (lfsr_en),
        .lfsr_seed (lfsr_seed),
        .lfsr_taps (lfsr_taps),
`ifdef XORC_BYTE_CNT_EN
        .byte_cnt  (byte_cnt),
`endif
        .lfsr_k    (lfsr_k)
    );

    // Keystream source: k is state bit 0, shift right and fold taps in when k=1.
    always @(posedge clk) begin
        if (lfsr_ld) begin
            lfsr_st <= lfsr_seed;
        end else if (lfsr_en) begin
            lfsr_st <= lfsr_st[0] ? ((lfsr_st >> 1) ^ lfsr_taps) : (lfsr_st >> 1);
        end
    end
    assign lfsr_k = lfsr_st[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [31:0] s, input logic [31:0] t);
        int n;
        seed_i  = s;
        taps_i  = t;
        seed_ld = 1'b1;
        @(negedge clk);
        seed_ld = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("load_done", {31'b0, busy}, 32'd0);
        chk("load_regs", lfsr_seed ^ lfsr_taps, s ^ t);
    endtask

    // Accept a word, check output latency and value, then complete the output handshake.
    task automatic do_word(input string name, input logic [7:0] din, input logic [7:0] exp);
        int n;
        int lat;
        in_data  = din;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_accept"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'd9);
        chk({name, "_data"}, {24'b0, out_data}, {24'b0, exp});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_drop"}, {31'b0, out_valid}, 32'd0);
    endtask

    typedef struct {
        logic        reload;
        logic [31:0] seed;
        logic [31:0] taps;
        logic [7:0]  din;
        logic [7:0]  dout;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int n;
        int hold_bad;

        vecs[0] = '{1'b1, 32'h0000_0001, 32'h8020_0003, 8'h00, 8'hDB};
        vecs[1] = '{1'b1, 32'h0000_0001, 32'h8020_0003, 8'hFF, 8'h24};
        vecs[2] = '{1'b0, 32'h0,         32'h0,         8'h00, 8'hB6};
        vecs[3] = '{1'b1, 32'h0000_0001, 32'h8020_0003, 8'hDB, 8'h00};
        vecs[4] = '{1'b1, 32'h0000_0001, 32'h8020_0003, 8'h5A, 8'h81};
        vecs[5] = '{1'b0, 32'h0,         32'h0,         8'hA5, 8'h13};
        vecs[6] = '{1'b1, 32'h0000_0003, 32'h0000_0000, 8'h00, 8'h03};
        vecs[7] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 8'h00, 8'hFF};
        vecs[8] = '{1'b0, 32'h0,         32'h0,         8'h0F, 8'hF0};

        rst_n     = 1'b0;
        seed_i    = '0;
        taps_i    = '0;
        seed_ld   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_lfsr_ctl", {30'b0, lfsr_ld, lfsr_en}, 32'd0);
        chk("rst_seed", lfsr_seed, 32'h0);
        chk("rst_taps", lfsr_taps, 32'h8020_0003);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Not seeded yet: no word may be accepted.
        in_valid = 1'b1;
        @(negedge clk);
        chk("unseeded_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].reload) begin
                do_load(vecs[i].seed, vecs[i].taps);
            end
            do_word($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout);
        end

        // Output back-pressure with a seed load arriving during the hold.
        do_load(32'h1, 32'h8020_0003);
        in_data  = 8'h00;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        hold_bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                seed_i  = 32'h3;
                taps_i  = 32'h0;
                seed_ld = 1'b1;
            end
            if (!out_valid || out_data !== 8'hDB || in_ready) hold_bad++;
            @(negedge clk);
            seed_ld = 1'b0;
        end
        chk("hold_stable", 32'(hold_bad), 32'd0);
        chk("hold_data", {24'b0, out_data}, 32'h0000_00DB);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("load_after_out", {31'b0, lfsr_ld}, 32'd1);
        @(negedge clk);
        do_word("after_hold", 8'h00, 8'h03);

        // seed_ld and in_valid together in IDLE: load wins, word follows.
        seed_i   = 32'h1;
        taps_i   = 32'h8020_0003;
        seed_ld  = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b1;
        #1;
        chk("coincide_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        seed_ld = 1'b0;
        chk("coincide_pend_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        chk("coincide_load", {31'b0, lfsr_ld}, 32'd1);
`ifdef XORC_BYTE_CNT_EN
        @(negedge clk);
        chk("byte_cnt_cleared", byte_cnt, 32'd0);
`endif
        do_word("coincide_word", 8'h00, 8'hDB);
`ifdef XORC_BYTE_CNT_EN
        chk("byte_cnt_one", byte_cnt, 32'd1);
`endif

        // Reset in the middle of generating a word.
        in_data  = 8'h55;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midgen_en", {31'b0, lfsr_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy_en", {30'b0, busy, lfsr_en}, 32'd0);
        chk("midrst_taps", lfsr_taps, 32'h8020_0003);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        hold_bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (in_ready || out_valid) hold_bad++;
        end
        chk("midrst_no_accept", 32'(hold_bad), 32'd0);
        in_valid = 1'b0;
        do_load(32'h1, 32'h8020_0003);
        do_word("post_rst", 8'h00, 8'hDB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
